// File: rtl/neighbor_link_pipelined_if.sv
// neighbor_link_pipelined_if: signal bundle between a grid link and its two neighbouring units
// Ports (slave = link side):
//   in : global_stage, weight_in, erase_in, a/b_increase, a/b_msg_in, a/b_parent_in, a/b_is_error_in
//   out: a/b_msg_out, a/b_parent_out, fully_grown, is_boundary, is_error, busy
interface neighbor_link_pipelined_if #(
    parameter int MSG_WIDTH      = 16,
    parameter int LINK_BIT_WIDTH = 3,
    parameter int STAGE_WIDTH    = 3
);
    logic [STAGE_WIDTH-1:0]    global_stage;
    logic [LINK_BIT_WIDTH-1:0] weight_in;
    logic                      erase_in;
    logic                      a_increase, b_increase;
    logic [MSG_WIDTH-1:0]      a_msg_in, b_msg_in, a_msg_out, b_msg_out;
    logic                      a_parent_in, b_parent_in, a_parent_out, b_parent_out;
    logic                      a_is_error_in, b_is_error_in;
    logic                      fully_grown, is_boundary, is_error, busy;

    modport master (
        output global_stage, weight_in, erase_in, a_increase, b_increase,
               a_msg_in, b_msg_in, a_parent_in, b_parent_in, a_is_error_in, b_is_error_in,
        input  a_msg_out, b_msg_out, a_parent_out, b_parent_out,
               fully_grown, is_boundary, is_error, busy
    );

    modport slave (
        input  global_stage, weight_in, erase_in, a_increase, b_increase,
               a_msg_in, b_msg_in, a_parent_in, b_parent_in, a_is_error_in, b_is_error_in,
        output a_msg_out, b_msg_out, a_parent_out, b_parent_out,
               fully_grown, is_boundary, is_error, busy
    );
endinterface

// File: rtl/neighbor_link_pipelined.sv
// neighbor_link_pipelined: union-find grid link with weighted growth and a retimed bidirectional message path
// Ports:
//   clk   : clock
//   reset : synchronous, active-high
//   link  : slave side of neighbor_link_pipelined_if (stage/weight/erasure load, growth requests,
//           message + parent bundles in both directions, error marks, fully_grown/is_boundary/is_error/busy)
module neighbor_link_pipelined #(
    parameter int MSG_WIDTH     = 16,
    parameter int PIPE_DEPTH    = 1,
    parameter int MAX_WEIGHT    = 7,
    parameter int BOUNDARY_MODE = 0,
    parameter int STAGE_WIDTH   = 3,
    parameter int STAGE_LOAD    = 1
) (
    input logic                     clk,
    input logic                     reset,
    neighbor_link_pipelined_if.slave link
);
    localparam int LBW = $clog2(MAX_WEIGHT + 1);
    localparam int QW  = $clog2(PIPE_DEPTH + 2);
    localparam int CW  = MSG_WIDTH + 1;
    localparam int SNW = 2 * MSG_WIDTH + 2;
    localparam logic [LBW-1:0] MAXW = LBW'(MAX_WEIGHT);
    // side b exists only for internal edges; side a exists unless the edge is absent
    localparam bit TWO_SIDED = BOUNDARY_MODE == 0 || BOUNDARY_MODE == 3;
    localparam bit A_SIDE    = BOUNDARY_MODE != 2;

    logic           load, fg;
    logic [LBW-1:0] w_clamp, wt_q, wt_d, growth_q, growth_d;
    logic [LBW:0]   sum;
    logic           err_q, err_d;
    logic [CW-1:0]  ab_d, ba_d;
    logic [SNW-1:0] snap_q, snap_d;
    logic [QW-1:0]  quiet_q, quiet_d;

    always_comb begin
        load     = link.global_stage == STAGE_WIDTH'(STAGE_LOAD);
        w_clamp  = link.weight_in > MAXW ? MAXW : link.weight_in;
        // one extra bit so a double increment cannot wrap before saturation
        sum      = {1'b0, growth_q} + (LBW+1)'(link.a_increase & A_SIDE) + (LBW+1)'(link.b_increase & TWO_SIDED);
        growth_d = load ? (link.erase_in ? w_clamp : '0) : !A_SIDE ? '0 : sum > {1'b0, wt_q} ? wt_q : sum[LBW-1:0];
        wt_d     = load ? w_clamp : wt_q;
        err_d    = !load && ((link.a_is_error_in && A_SIDE) || (link.b_is_error_in && TWO_SIDED));
        ab_d     = {link.a_msg_in, link.a_parent_in & TWO_SIDED};
        ba_d     = {link.b_msg_in, link.b_parent_in & TWO_SIDED};
        snap_d   = {link.a_msg_in, link.b_msg_in, link.a_parent_in, link.b_parent_in};
        // any input change restarts the settle window; otherwise count down to zero
        quiet_d  = snap_d != snap_q ? QW'(PIPE_DEPTH + 1) : quiet_q - QW'(quiet_q != '0);
        fg       = BOUNDARY_MODE == 2 ? 1'b0 : BOUNDARY_MODE == 3 ? 1'b1 : growth_q >= wt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wt_q     <= MAXW;
            growth_q <= '0;
            err_q    <= 1'b0;
            snap_q   <= '0;
            quiet_q  <= '0;
        end else begin
            wt_q     <= wt_d;
            growth_q <= growth_d;
            err_q    <= err_d;
            snap_q   <= snap_d;
            quiet_q  <= quiet_d;
        end
    end

    assign link.fully_grown = fg;
    assign link.is_boundary = BOUNDARY_MODE == 1 && fg;
    assign link.is_error    = err_q;
    assign link.busy        = quiet_q != '0;

    if (PIPE_DEPTH == 0) begin : g_comb
        assign {link.b_msg_out, link.b_parent_out} = ab_d;
        assign {link.a_msg_out, link.a_parent_out} = ba_d;
    end else begin : g_pipe
        logic [CW-1:0] ab_q [PIPE_DEPTH];
        logic [CW-1:0] ba_q [PIPE_DEPTH];
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DEPTH; i++) begin
                    ab_q[i] <= '0;
                    ba_q[i] <= '0;
                end
            end else begin
                ab_q[0] <= ab_d;
                ba_q[0] <= ba_d;
                for (int i = 1; i < PIPE_DEPTH; i++) begin
                    ab_q[i] <= ab_q[i-1];
                    ba_q[i] <= ba_q[i-1];
                end
            end
        end
        assign {link.b_msg_out, link.b_parent_out} = ab_q[PIPE_DEPTH-1];
        assign {link.a_msg_out, link.a_parent_out} = ba_q[PIPE_DEPTH-1];
    end
endmodule

// File: tb/tb_neighbor_link_pipelined.sv
// tb_neighbor_link_pipelined: four link variants driven side by side, scored against a behavioural model
module tb_neighbor_link_pipelined;
    localparam int N   = 4;
    localparam int MW  = 16;
    localparam int LBW = 3;
    localparam int SW  = 3;
    localparam int MODE [N] = '{0, 1, 2, 3};
    localparam int PDS  [N] = '{3, 1, 0, 2};
    localparam int MAXW [N] = '{6, 7, 7, 7};

    typedef struct packed {
        logic [MW-1:0] am, bm;
        logic ap, bp, fg, ib, ie, bs;
    } obs_t;
    typedef obs_t [N-1:0] obs4_t;

    logic clk = 1'b0;
    logic reset;
    logic [SW-1:0] stage;
    logic [LBW-1:0] weight [N];
    logic erase [N], ai [N], bi [N], ae [N], be [N], ap [N], bp [N];
    logic [MW-1:0] am [N], bm [N];
    obs_t got [N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        neighbor_link_pipelined_if #(.MSG_WIDTH(MW), .LINK_BIT_WIDTH(LBW), .STAGE_WIDTH(SW)) ifc ();
        assign ifc.global_stage  = stage;
        assign ifc.weight_in     = weight[g];
        assign ifc.erase_in      = erase[g];
        assign ifc.a_increase    = ai[g];
        assign ifc.b_increase    = bi[g];
        assign ifc.a_msg_in      = am[g];
        assign ifc.b_msg_in      = bm[g];
        assign ifc.a_parent_in   = ap[g];
        assign ifc.b_parent_in   = bp[g];
        assign ifc.a_is_error_in = ae[g];
        assign ifc.b_is_error_in = be[g];
        neighbor_link_pipelined #(
            .MSG_WIDTH(MW), .PIPE_DEPTH(PDS[g]), .MAX_WEIGHT(MAXW[g]),
            .BOUNDARY_MODE(MODE[g]), .STAGE_WIDTH(SW), .STAGE_LOAD(1)
        ) dut (.clk(clk), .reset(reset), .link(ifc.slave));
        assign got[g] = {ifc.a_msg_out, ifc.b_msg_out, ifc.a_parent_out, ifc.b_parent_out,
                         ifc.fully_grown, ifc.is_boundary, ifc.is_error, ifc.busy};
    end

    // reference model state
    int wt [N], gr [N], age [N];
    bit err [N];
    logic [2*MW+1:0] snap [N];
    logic [MW:0] hist_ab [N][$];
    logic [MW:0] hist_ba [N][$];
    obs4_t q [$];
    int total = 0, bad = 0;
    bit run = 0;

    function automatic int mn(int a, int b);
        return a < b ? a : b;
    endfunction

    function automatic bit pass_parent(int k);
        return MODE[k] == 0 || MODE[k] == 3;
    endfunction

    // advance the model across one clock edge using the inputs that were applied before it
    task automatic step_model();
        for (int k = 0; k < N; k++) begin
            logic [2*MW+1:0] cur;
            cur = {am[k], bm[k], ap[k], bp[k]};
            if (reset) begin
                wt[k] = MAXW[k]; gr[k] = 0; err[k] = 0; age[k] = 1000; snap[k] = '0;
                hist_ab[k].delete(); hist_ba[k].delete();
                for (int i = 0; i < PDS[k]; i++) begin
                    hist_ab[k].push_back('0);
                    hist_ba[k].push_back('0);
                end
            end else begin
                if (stage == SW'(1)) begin
                    int w;
                    w = mn(int'(weight[k]), MAXW[k]);
                    wt[k] = w; gr[k] = erase[k] ? w : 0; err[k] = 0;
                end else begin
                    if (MODE[k] == 0 || MODE[k] == 3) gr[k] = mn(gr[k] + int'(ai[k]) + int'(bi[k]), wt[k]);
                    else if (MODE[k] == 1) gr[k] = mn(gr[k] + int'(ai[k]), wt[k]);
                    else gr[k] = 0;
                    err[k] = (MODE[k] == 0 || MODE[k] == 3) ? (ae[k] | be[k]) : MODE[k] == 1 ? ae[k] : 1'b0;
                end
                age[k] = (cur != snap[k]) ? 0 : mn(age[k] + 1, 1000);
                snap[k] = cur;
                if (PDS[k] > 0) begin
                    hist_ab[k].push_front({am[k], ap[k] & pass_parent(k)});
                    hist_ba[k].push_front({bm[k], bp[k] & pass_parent(k)});
                    void'(hist_ab[k].pop_back());
                    void'(hist_ba[k].pop_back());
                end
            end
        end
    endtask

    function automatic obs_t expect_k(int k);
        obs_t o;
        logic [MW:0] xab, xba;
        if (PDS[k] == 0) begin
            xab = {am[k], ap[k] & pass_parent(k)};
            xba = {bm[k], bp[k] & pass_parent(k)};
        end else begin
            xab = hist_ab[k][PDS[k]-1];
            xba = hist_ba[k][PDS[k]-1];
        end
        o.bm = xab[MW:1]; o.bp = xab[0];
        o.am = xba[MW:1]; o.ap = xba[0];
        o.fg = MODE[k] == 2 ? 1'b0 : MODE[k] == 3 ? 1'b1 : gr[k] >= wt[k];
        o.ib = MODE[k] == 1 && o.fg;
        o.ie = err[k];
        o.bs = age[k] < PDS[k] + 1;
        return o;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        step_model();
    endtask

    task automatic apply();
        obs4_t e;
        for (int k = 0; k < N; k++) e[k] = expect_k(k);
        q.push_back(e);
        run = 1;
    endtask

    task automatic set_inc(input logic a, input logic b);
        for (int k = 0; k < N; k++) begin ai[k] = a; bi[k] = b; end
    endtask

    task automatic set_load(input logic [LBW-1:0] w, input logic e);
        stage = SW'(1);
        for (int k = 0; k < N; k++) begin weight[k] = w; erase[k] = e; end
    endtask

    task automatic chk(input string n, input int k, input logic [MW-1:0] g, input logic [MW-1:0] x);
        total++;
        if (g !== x) begin
            bad++;
            $display("FAIL %s inst%0d got=%h exp=%h at %0t", n, k, g, x, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (q.size() == 0) begin
                total++; bad++;
                $display("FAIL scoreboard_empty got=0 exp=1 at %0t", $time);
            end else begin
                obs4_t e;
                e = q.pop_front();
                for (int k = 0; k < N; k++) begin
                    chk("a_msg_out", k, got[k].am, e[k].am);
                    chk("b_msg_out", k, got[k].bm, e[k].bm);
                    chk("a_parent_out", k, MW'(got[k].ap), MW'(e[k].ap));
                    chk("b_parent_out", k, MW'(got[k].bp), MW'(e[k].bp));
                    chk("fully_grown", k, MW'(got[k].fg), MW'(e[k].fg));
                    chk("is_boundary", k, MW'(got[k].ib), MW'(e[k].ib));
                    chk("is_error", k, MW'(got[k].ie), MW'(e[k].ie));
                    chk("busy", k, MW'(got[k].bs), MW'(e[k].bs));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        stage = '0;
        for (int k = 0; k < N; k++) begin
            weight[k] = '0; erase[k] = 0; ai[k] = 0; bi[k] = 0; ae[k] = 0; be[k] = 0;
            ap[k] = 0; bp[k] = 0; am[k] = '0; bm[k] = '0;
        end
        repeat (2) begin tick(); apply(); end
        tick(); reset = 1'b0; apply();
        // weight 3, double increment then single increment, then further increments
        tick(); set_load(3'd3, 1'b0); apply();
        tick(); stage = '0; set_inc(1, 1); apply();
        tick(); set_inc(1, 0); apply();
        repeat (3) begin tick(); set_inc(1, 1); apply(); end
        tick(); set_inc(0, 0); apply();
        // largest encodable weight with erasure: clamps where MAX_WEIGHT is smaller
        tick(); set_load(3'd7, 1'b1); apply();
        tick(); stage = '0; for (int k = 0; k < N; k++) erase[k] = 0; apply();
        tick(); apply();
        // weight 2: b-only pulses, then a-only pulses, then b-side error
        tick(); set_load(3'd2, 1'b0); apply();
        tick(); stage = '0; apply();
        repeat (5) begin
            tick(); set_inc(0, 1); apply();
            tick(); set_inc(0, 0); apply();
        end
        repeat (2) begin
            tick(); set_inc(1, 0); apply();
            tick(); set_inc(0, 0); apply();
        end
        tick(); for (int k = 0; k < N; k++) be[k] = 1; apply();
        repeat (2) begin tick(); apply(); end
        tick(); for (int k = 0; k < N; k++) begin be[k] = 0; ae[k] = 1; end apply();
        tick(); for (int k = 0; k < N; k++) ae[k] = 0; apply();
        // randomized traffic
        repeat (400) begin
            tick();
            stage = SW'($urandom_range(0, 7));
            for (int k = 0; k < N; k++) begin
                weight[k] = LBW'($urandom); erase[k] = 1'($urandom);
                ai[k] = 1'($urandom); bi[k] = 1'($urandom);
                ae[k] = 1'($urandom); be[k] = 1'($urandom);
                if ($urandom_range(0, 2) == 0) begin
                    am[k] = MW'($urandom); bm[k] = MW'($urandom);
                    ap[k] = 1'($urandom); bp[k] = 1'($urandom);
                end
            end
            apply();
        end
        tick(); stage = '0; set_inc(0, 0); apply();
        // counter stream on side a, then hold so busy can settle
        for (int i = 0; i < 10; i++) begin
            tick(); for (int k = 0; k < N; k++) am[k] = MW'(i + 1); apply();
        end
        repeat (8) begin tick(); apply(); end
        // reset mid-stream with growth at 2
        tick(); set_load(3'd5, 1'b0); apply();
        tick(); stage = '0; set_inc(1, 0); apply();
        tick(); for (int k = 0; k < N; k++) am[k] = 16'h00a5; apply();
        tick(); reset = 1'b1; for (int k = 0; k < N; k++) am[k] = 16'h005a; apply();
        tick(); reset = 1'b0; apply();
        repeat (8) begin tick(); for (int k = 0; k < N; k++) am[k] = am[k] + 1; apply(); end
        tick(); set_inc(0, 0); apply();
        repeat (6) begin tick(); apply(); end
        @(negedge clk);
        #1;
        run = 0;
        if (q.size() != 0) begin
            total++; bad++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
